cp0_exc_ctrl: RTL and testbench
===============================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 excepttype_i  in  32  prioritized exception code from MEM stage; 0 = none.
REQ-004 pc_i  in  32  PC of faulting MEM-stage instruction.
REQ-005 is_in_delayslot_i  in  1  faulting instruction sits in a branch delay slot.
REQ-006 bad_addr_i  in  32  faulting virtual address (fetch or data).
REQ-007 we_i / waddr_i / wdata_i  in  1/5/32  mtc0 write port.
REQ-008 raddr_i  in  5;  rdata_o  out  32  mfc0 read port.
REQ-009 int_i  in  6  external hardware interrupt lines, level-sensitive.
REQ-010 status_o, cause_o, epc_o  out  32 each  current register values, fed back to the exception encoder.
REQ-011 flush_o  out  1  pipeline flush request.
REQ-012 newpc_o  out  32  redirect target, valid when flush_o=1.
REQ-013 timer_int_o  out  1  mirror of Cause.TI.

Function
REQ-014 Registers SHALL be BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15, constant 0x00004220); other addresses SHALL read 0.
REQ-015 rdata_o SHALL be combinational from raddr_i; there is no bypass of a same-cycle write.
REQ-016 Writable masks: Status bits 22, 15:8, 1, 0; Cause bits 9:8; Count, Compare, EPC full width; BadVAddr read-only.
REQ-017 Code table: 0x01 ExcCode 0; 0x04 ExcCode 4; 0x05 ExcCode 5; 0x08 ExcCode 8; 0x09 ExcCode 9; 0x0a ExcCode 10; 0x0b ExcCode 11; 0x0c ExcCode 12; 0x0d ExcCode 13; 0x10/0x11/0x12 ExcCode 2; 0x13 ExcCode 3; 0x14 ExcCode 1; 0x0e = eret.
REQ-018 Any other nonzero code SHALL be ignored: no flush and no state change.
REQ-019 On a valid non-eret code, flush_o SHALL assert combinationally in the same cycle.
REQ-020 On that code's clock edge: Cause.ExcCode updated; Status.EXL set.
REQ-021 If Status.EXL was 0 on that edge: EPC = is_in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD = is_in_delayslot_i.
REQ-022 If Status.EXL was already 1: EPC and Cause.BD SHALL be unchanged.
REQ-023 BadVAddr SHALL load bad_addr_i only for codes 0x04, 0x05, 0x10-0x14.
REQ-024 newpc_o SHALL be 0xBFC00200 for codes 0x10/0x12 with EXL=0, and 0xBFC00380 otherwise.
REQ-025 On eret (0x0e): flush_o=1 and newpc_o=EPC combinationally; Status.EXL SHALL clear on the edge.
REQ-026 An exception or eret in the same cycle as we_i SHALL suppress the mtc0 write entirely.
REQ-027 Count SHALL increment by 1 every second cycle via an internal toggle; wrap at 2^32 SHALL be silent.
REQ-028 A Count write SHALL load the value and restart the toggle phase.
REQ-029 Cause.TI (bit 30) SHALL set on the edge after Count increments to a value equal to Compare.
REQ-030 Cause.TI SHALL clear only on a Compare write; a simultaneous set and clear SHALL resolve to clear.
REQ-031 Cause.IP[7:2] SHALL be updated each cycle to {int_i[5]|TI, int_i[4:0]}.

Reset
REQ-032 On rst: Status=0x00400000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0.
REQ-033 During rst, flush_o=0 and newpc_o=0; rst asserted mid-exception SHALL override the update.

Structure
REQ-034 Package cp0_pkg SHALL hold register addresses, excepttype codes, ExcCode values, vector addresses and the PRId constant.
REQ-035 Count/Compare/TI logic SHALL be a sub-module, cp0_timer.

Verification
REQ-036 Delay-slot Ov: excepttype=0x0c, pc=0xBFC00104, delayslot=1 -> flush_o=1, newpc=0xBFC00380; next cycle EPC=0xBFC00100, BD=1, ExcCode=12, EXL=1.
REQ-037 AdEL on fetch: code 0x04, bad_addr=0x80000003 -> BadVAddr=0x80000003, ExcCode=4.
REQ-038 Nested exception, EXL=1: code 0x08, pc=0x1000 -> EPC unchanged, ExcCode=8.
REQ-039 Eret with EPC=0xBFC00500: code 0x0e -> newpc=0xBFC00500; next cycle EXL=0.
REQ-040 Timer: Compare=5, Count=0 -> TI=1 on the cycle after Count reaches 5 (~10 cycles); Compare write clears TI.
REQ-041 Collision: mtc0 Status=0x1 in the same cycle as code 0x09 -> Status IE unchanged, ExcCode=9.
REQ-042 Unknown code 0x07 -> flush_o=0 and all registers unchanged.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 register map, MEM-stage exception codes, ExcCode values and vectors,
// plus the decoder shared by the exception controller.
package cp0_pkg;

    // CP0 register addresses (mfc0/mtc0 rd field)
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;

    localparam int unsigned STATUS_EXL = 1;

    // excepttype_i encodings produced by the MEM stage
    localparam logic [31:0] ET_INT    = 32'h0000_0001;
    localparam logic [31:0] ET_ADEL   = 32'h0000_0004;
    localparam logic [31:0] ET_ADES   = 32'h0000_0005;
    localparam logic [31:0] ET_SYS    = 32'h0000_0008;
    localparam logic [31:0] ET_BP     = 32'h0000_0009;
    localparam logic [31:0] ET_RI     = 32'h0000_000a;
    localparam logic [31:0] ET_CPU    = 32'h0000_000b;
    localparam logic [31:0] ET_OV     = 32'h0000_000c;
    localparam logic [31:0] ET_TR     = 32'h0000_000d;
    localparam logic [31:0] ET_ERET   = 32'h0000_000e;
    localparam logic [31:0] ET_TLBL_I = 32'h0000_0010;
    localparam logic [31:0] ET_TLBL_D = 32'h0000_0011;
    localparam logic [31:0] ET_TLBL_R = 32'h0000_0012;
    localparam logic [31:0] ET_TLBS   = 32'h0000_0013;
    localparam logic [31:0] ET_MOD    = 32'h0000_0014;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [31:0] VEC_REFILL  = 32'hBFC0_0200;
    localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;

    typedef struct packed {
        logic       exc;       // real exception (not eret)
        logic       eret;
        logic [4:0] exccode;
        logic       load_bad;  // latch bad_addr_i into BadVAddr
        logic       refill;    // eligible for the refill vector when EXL=0
    } exc_info_t;

    function automatic exc_info_t decode_exc(input logic [31:0] code);
        exc_info_t r;
        r = '0;
        case (code)
            ET_INT:    begin r.exc = 1'b1; r.exccode = EXC_INT; end
            ET_ADEL:   begin r.exc = 1'b1; r.exccode = EXC_ADEL; r.load_bad = 1'b1; end
            ET_ADES:   begin r.exc = 1'b1; r.exccode = EXC_ADES; r.load_bad = 1'b1; end
            ET_SYS:    begin r.exc = 1'b1; r.exccode = EXC_SYS; end
            ET_BP:     begin r.exc = 1'b1; r.exccode = EXC_BP; end
            ET_RI:     begin r.exc = 1'b1; r.exccode = EXC_RI; end
            ET_CPU:    begin r.exc = 1'b1; r.exccode = EXC_CPU; end
            ET_OV:     begin r.exc = 1'b1; r.exccode = EXC_OV; end
            ET_TR:     begin r.exc = 1'b1; r.exccode = EXC_TR; end
            ET_ERET:   begin r.eret = 1'b1; end
            ET_TLBL_I: begin r.exc = 1'b1; r.exccode = EXC_TLBL; r.load_bad = 1'b1; r.refill = 1'b1; end
            ET_TLBL_D: begin r.exc = 1'b1; r.exccode = EXC_TLBL; r.load_bad = 1'b1; end
            ET_TLBL_R: begin r.exc = 1'b1; r.exccode = EXC_TLBL; r.load_bad = 1'b1; r.refill = 1'b1; end
            ET_TLBS:   begin r.exc = 1'b1; r.exccode = EXC_TLBS; r.load_bad = 1'b1; end
            ET_MOD:    begin r.exc = 1'b1; r.exccode = EXC_MOD; r.load_bad = 1'b1; end
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// Count-reaches-Compare increment and clears only on a Compare write.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic toggle;
    logic inc_d;   // Count was incremented on the previous edge

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            toggle  <= 1'b0;
            inc_d   <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count  <= wdata;
                toggle <= 1'b0;
                inc_d  <= 1'b0;
            end else begin
                toggle <= ~toggle;
                inc_d  <= toggle;
                if (toggle)
                    count <= count + 32'd1;
            end

            if (compare_we)
                compare <= wdata;

            // Compare write wins over a coincident match
            if (compare_we)
                ti <= 1'b0;
            else if (inc_d && (count == compare))
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC/BadVAddr state, exception entry
// and eret redirect, mtc0/mfc0 access and the Count/Compare timer.
module cp0_exc_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        timer_int_o
);

    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    exc_info_t   info;
    logic        take;
    logic        mtc0;
    logic [31:0] cause;

    assign info = decode_exc(excepttype_i);
    assign take = info.exc | info.eret;
    // An exception or eret in the same cycle drops the mtc0 entirely
    assign mtc0 = we_i & ~take;

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0 && (waddr_i == REG_COUNT)),
        .compare_we (mtc0 && (waddr_i == REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            status        <= STATUS_RESET;
            epc           <= '0;
            badvaddr      <= '0;
            cause_bd      <= 1'b0;
            cause_ip_hw   <= '0;
            cause_ip_sw   <= '0;
            cause_exccode <= '0;
        end else begin
            cause_ip_hw <= {int_i[5] | ti, int_i[4:0]};

            if (info.exc) begin
                cause_exccode      <= info.exccode;
                status[STATUS_EXL] <= 1'b1;
                if (!status[STATUS_EXL]) begin
                    epc      <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_bd <= is_in_delayslot_i;
                end
                if (info.load_bad)
                    badvaddr <= bad_addr_i;
            end else if (info.eret) begin
                status[STATUS_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    REG_STATUS: status      <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                    REG_CAUSE:  cause_ip_sw <= wdata_i[9:8];
                    REG_EPC:    epc         <= wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    assign cause = {cause_bd, ti, 14'd0, cause_ip_hw, cause_ip_sw,
                    1'b0, cause_exccode, 2'b00};

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr;
            REG_COUNT:    rdata_o = count;
            REG_COMPARE:  rdata_o = compare;
            REG_STATUS:   rdata_o = status;
            REG_CAUSE:    rdata_o = cause;
            REG_EPC:      rdata_o = epc;
            REG_PRID:     rdata_o = PRID_VALUE;
            default:      rdata_o = '0;
        endcase
    end

    always_comb begin
        flush_o = 1'b0;
        newpc_o = '0;
        if (!rst && take) begin
            flush_o = 1'b1;
            if (info.eret)
                newpc_o = epc;
            else if (info.refill && !status[STATUS_EXL])
                newpc_o = VEC_REFILL;
            else
                newpc_o = VEC_GENERAL;
        end
    end

    assign status_o    = status;
    assign cause_o     = cause;
    assign epc_o       = epc;
    assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expected values.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        timer_int_o;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .excepttype_i      (excepttype_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .bad_addr_i        (bad_addr_i),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .int_i             (int_i),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .flush_o           (flush_o),
        .newpc_o           (newpc_o),
        .timer_int_o       (timer_int_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        raddr_i = a;
        #1;
        chk(tag, rdata_o, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds, input logic [31:0] bad);
        excepttype_i = code; pc_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
        #1;
    endtask

    initial begin
        rst = 1'b1; excepttype_i = '0; pc_i = '0; is_in_delayslot_i = 1'b0;
        bad_addr_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; int_i = '0;

        // reset, including an exception presented while in reset
        step(); step();
        exc(32'h0c, 32'h1234, 1'b0, 32'h0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_newpc", newpc_o, 32'd0);
        step();
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'd0);
        chk("rst_epc", epc_o, 32'd0);
        rd(5'd9, "rst_count", 32'd0);
        rd(5'd8, "rst_badvaddr", 32'd0);
        rd(5'd11, "rst_compare", 32'd0);
        rd(5'd15, "prid", 32'h0000_4220);
        rd(5'd0, "unmapped0", 32'd0);
        rd(5'd10, "unmapped10", 32'd0);
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        step();

        // delay-slot overflow
        exc(32'h0c, 32'hBFC0_0104, 1'b1, 32'h0);
        chk("ov_flush", {31'd0, flush_o}, 32'd1);
        chk("ov_newpc", newpc_o, 32'hBFC0_0380);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("ov_epc", epc_o, 32'hBFC0_0100);
        chk("ov_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("ov_exccode", {27'd0, cause_o[6:2]}, 32'd12);
        chk("ov_status", status_o, 32'h0040_0002);

        // AdEL while EXL=1: BadVAddr loads, EPC/BD hold
        exc(32'h04, 32'h4444, 1'b0, 32'h8000_0003);
        chk("adel_newpc", newpc_o, 32'hBFC0_0380);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        rd(5'd8, "adel_badvaddr", 32'h8000_0003);
        chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
        chk("adel_epc", epc_o, 32'hBFC0_0100);
        chk("adel_bd", {31'd0, cause_o[31]}, 32'd1);

        // nested syscall: EPC unchanged, BadVAddr not loaded
        exc(32'h08, 32'h1000, 1'b0, 32'h1234_5678);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
        rd(5'd8, "sys_badvaddr", 32'h8000_0003);

        // eret to a written EPC
        wr(5'd14, 32'hBFC0_0500);
        chk("epc_write", epc_o, 32'hBFC0_0500);
        exc(32'h0e, 32'h0, 1'b0, 32'h0);
        chk("eret_flush", {31'd0, flush_o}, 32'd1);
        chk("eret_newpc", newpc_o, 32'hBFC0_0500);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("eret_status", status_o, 32'h0040_0000);

        // refill-vector codes depend on EXL
        exc(32'h10, 32'h2000, 1'b0, 32'h55);
        chk("tlb10_newpc", newpc_o, 32'hBFC0_0200);
        step();
        exc(32'h12, 32'h2100, 1'b0, 32'h66);
        chk("tlb12_exl_newpc", newpc_o, 32'hBFC0_0380);
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("tlb10_epc", epc_o, 32'h2000);
        chk("tlb10_cause", cause_o, 32'h0000_0008);
        rd(5'd8, "tlb10_badvaddr", 32'h55);
        exc(32'h0e, 32'h0, 1'b0, 32'h0);
        chk("eret2_newpc", newpc_o, 32'h2000);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("eret2_status", status_o, 32'h0040_0000);

        // mtc0 Status colliding with breakpoint
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h1;
        exc(32'h09, 32'h3000, 1'b0, 32'h77);
        step();
        we_i = 1'b0;
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("coll_status", status_o, 32'h0040_0002);
        chk("coll_exccode", {27'd0, cause_o[6:2]}, 32'd9);
        chk("coll_epc", epc_o, 32'h3000);
        exc(32'h0e, 32'h0, 1'b0, 32'h0);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);

        // unknown code is ignored
        exc(32'h07, 32'h9999, 1'b1, 32'h77);
        chk("unk_flush", {31'd0, flush_o}, 32'd0);
        step();
        exc(32'h0, 32'h0, 1'b0, 32'h0);
        chk("unk_status", status_o, 32'h0040_0000);
        chk("unk_epc", epc_o, 32'h3000);
        chk("unk_cause", cause_o, 32'h0000_0024);
        rd(5'd8, "unk_badvaddr", 32'h55);

        // write masks
        wr(5'd12, 32'hFFFF_FFFF);
        chk("status_mask1", status_o, 32'h0040_FF03);
        wr(5'd12, 32'h0);
        chk("status_mask0", status_o, 32'h0);
        wr(5'd12, 32'h0040_0000);
        wr(5'd13, 32'hFFFF_FFFF);
        chk("cause_mask", cause_o, 32'h0000_0324);
        wr(5'd8, 32'hDEAD_BEEF);
        rd(5'd8, "badvaddr_ro", 32'h55);

        // hardware interrupt lines into IP[7:2]
        int_i = 6'b000101;
        step();
        chk("cause_ip", cause_o, 32'h0000_1724);
        int_i = 6'b000000;
        step();

        // timer match
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        for (int i = 0; i < 10; i++) step();
        rd(5'd9, "tmr_count5", 32'd5);
        chk("tmr_ti_pre", {31'd0, timer_int_o}, 32'd0);
        step();
        chk("tmr_ti_set", {31'd0, timer_int_o}, 32'd1);
        chk("tmr_cause_ti", {31'd0, cause_o[30]}, 32'd1);
        step();
        chk("tmr_ip7", {31'd0, cause_o[15]}, 32'd1);
        rd(5'd9, "tmr_count6", 32'd6);
        wr(5'd11, 32'd5);
        chk("tmr_ti_clr", {31'd0, timer_int_o}, 32'd0);

        // Compare write coinciding with a match edge resolves to clear
        wr(5'd9, 32'd0);
        for (int i = 0; i < 10; i++) step();
        wr(5'd11, 32'd5);
        chk("tmr_race", {31'd0, timer_int_o}, 32'd0);
        step();
        chk("tmr_race2", {31'd0, timer_int_o}, 32'd0);

        // silent wrap
        wr(5'd9, 32'hFFFF_FFFF);
        step();
        rd(5'd9, "wrap_pre", 32'hFFFF_FFFF);
        step();
        rd(5'd9, "wrap_post", 32'd0);
        chk("wrap_ti", {31'd0, timer_int_o}, 32'd0);

        // reset asserted during an exception overrides it
        rst = 1'b1;
        exc(32'h0c, 32'h5000, 1'b0, 32'h0);
        chk("rst2_flush", {31'd0, flush_o}, 32'd0);
        step();
        chk("rst2_status", status_o, 32'h0040_0000);
        chk("rst2_epc", epc_o, 32'd0);
        chk("rst2_cause", cause_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
